// File: rtl/delay_bank.sv
// delay_bank: multi-channel fractional delay-line engine.
// Up to N_CH circular buffers are carved out of one dual-port RAM. Each
// accepted sample is written into its channel and a delayed, linearly
// interpolated, fade-in-scaled sample is returned six edges later.
// Ports:
//   clk, reset (sync, active-high), enable (freezes all state when low)
//   alloc_req/alloc_size/alloc_delay -> alloc_ack/alloc_err/alloc_handle
//   req_valid/req_ready, req_handle, req_sample, req_delay_inc -> req_err
//   resp_valid, resp_handle, resp_sample
module delay_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int N_CH       = 8,
  parameter int MEM_DEPTH  = 4096,
  parameter int FRAC_BITS  = 8,
  parameter int RAMP_STEP  = 64,
  parameter int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int ADDR_W     = $clog2(MEM_DEPTH),
  parameter int DLY_W      = ADDR_W + FRAC_BITS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         alloc_req,
  input  logic [ADDR_W-1:0]            alloc_size,
  input  logic [DLY_W-1:0]             alloc_delay,
  output logic                         alloc_ack,
  output logic                         alloc_err,
  output logic [CH_W-1:0]              alloc_handle,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [CH_W-1:0]              req_handle,
  input  logic signed [DATA_WIDTH-1:0] req_sample,
  input  logic signed [DATA_WIDTH-1:0] req_delay_inc,
  output logic                         req_err,
  output logic                         resp_valid,
  output logic [CH_W-1:0]              resp_handle,
  output logic signed [DATA_WIDTH-1:0] resp_sample
);

  localparam int GAIN_W    = 15;
  localparam int GAIN_FRAC = 14;
  localparam int UNITY_INT = 16384;
  localparam int MIX_W     = DATA_WIDTH + FRAC_BITS + 1;
  localparam int PROD_W    = MIX_W + GAIN_W + 1;
  localparam int SUM_W     = ((DLY_W > DATA_WIDTH) ? DLY_W : DATA_WIDTH) + 2;
  localparam logic [GAIN_W:0] UNITY = (GAIN_W+1)'(UNITY_INT);
  localparam logic signed [PROD_W-1:0] SAT_HI =
    {{(PROD_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SAT_LO =
    {{(PROD_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, WRITE, RD_A, RD_B, MIX, GAIN, OUT} state_t;
  state_t state, next_state;

  // Channel table
  logic [ADDR_W-1:0] ch_base  [N_CH];
  logic [ADDR_W-1:0] ch_size  [N_CH];
  logic [ADDR_W-1:0] ch_pos   [N_CH];
  logic [GAIN_W-1:0] ch_gain  [N_CH];
  logic              ch_wrap  [N_CH];
  logic [DLY_W-1:0]  ch_delay [N_CH];
  logic [CH_W:0]     count;
  logic [ADDR_W:0]   next_base;

  // Latched request and pipeline registers
  logic [CH_W-1:0]              lat_handle;
  logic signed [DATA_WIDTH-1:0] lat_sample, lat_inc, a_q, out_q;
  logic signed [MIX_W-1:0]      y_q;

  // RAM
  logic signed [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic signed [DATA_WIDTH-1:0] rd_q;
  logic [ADDR_W-1:0]            wr_addr, rd_addr;

  // Combinational datapath
  logic [ADDR_W-1:0]            cur_base, cur_size, cur_pos, d_int, a_idx, b_idx, pos_next;
  logic [FRAC_BITS-1:0]         frac;
  logic [GAIN_W-1:0]            cur_gain, gain_next;
  logic [GAIN_W:0]              gain_sum;
  logic                         cur_wrap, pos_wrap, alloc_ok, handle_ok;
  logic [DLY_W-1:0]             cur_delay, dly_next, alloc_dly;
  logic signed [SUM_W-1:0]      inc_ext;
  logic signed [MIX_W-1:0]      a_ext, b_ext, f_ext, mix_prod, y_next;
  logic signed [PROD_W-1:0]     y_wide, g_wide, gain_prod, gain_shift;
  logic signed [DATA_WIDTH-1:0] sat_out;

  // Holds delay in [0, ((size-1) << FRAC_BITS) - 1].
  function automatic logic [DLY_W-1:0] clamp_dly(input logic signed [SUM_W-1:0] v,
                                                 input logic [ADDR_W-1:0] sz);
    logic [SUM_W-1:0]        hi_u;
    logic signed [SUM_W-1:0] hi;
    hi_u = ((SUM_W'(sz) - SUM_W'(1)) << FRAC_BITS) - SUM_W'(1);
    hi   = signed'(hi_u);
    if (v < 0)       return '0;
    else if (v > hi) return hi[DLY_W-1:0];
    else             return v[DLY_W-1:0];
  endfunction

  always_comb begin
    cur_base  = ch_base[lat_handle];
    cur_size  = ch_size[lat_handle];
    cur_pos   = ch_pos[lat_handle];
    cur_gain  = ch_gain[lat_handle];
    cur_wrap  = ch_wrap[lat_handle];
    cur_delay = ch_delay[lat_handle];
    d_int     = cur_delay[DLY_W-1:FRAC_BITS];
    frac      = cur_delay[FRAC_BITS-1:0];

    a_idx   = (cur_pos >= d_int) ? cur_pos - d_int : cur_pos + cur_size - d_int;
    b_idx   = (a_idx == '0) ? cur_size - ADDR_W'(1) : a_idx - ADDR_W'(1);
    wr_addr = cur_base + cur_pos;
    rd_addr = cur_base + ((state == RD_B) ? b_idx : a_idx);

    a_ext    = a_q;
    b_ext    = rd_q;
    f_ext    = MIX_W'(frac);
    mix_prod = (b_ext - a_ext) * f_ext;
    y_next   = a_ext + (mix_prod >>> FRAC_BITS);

    y_wide     = y_q;
    g_wide     = PROD_W'(cur_gain);
    gain_prod  = y_wide * g_wide;
    gain_shift = gain_prod >>> GAIN_FRAC;
    if (gain_shift > SAT_HI)      sat_out = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (gain_shift < SAT_LO) sat_out = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                          sat_out = gain_shift[DATA_WIDTH-1:0];

    pos_wrap  = (cur_pos == cur_size - ADDR_W'(1));
    pos_next  = pos_wrap ? '0 : cur_pos + ADDR_W'(1);
    gain_sum  = {1'b0, cur_gain} + (GAIN_W+1)'(RAMP_STEP);
    gain_next = cur_gain;
    if (cur_wrap) gain_next = (gain_sum >= UNITY) ? UNITY[GAIN_W-1:0] : gain_sum[GAIN_W-1:0];
    inc_ext   = lat_inc;
    dly_next  = clamp_dly(signed'(SUM_W'(cur_delay)) + inc_ext, cur_size);
    alloc_dly = clamp_dly(signed'(SUM_W'(alloc_delay)), alloc_size);

    alloc_ok  = (count < (CH_W+1)'(N_CH)) && (alloc_size >= ADDR_W'(2)) &&
                ((next_base + (ADDR_W+1)'(alloc_size)) <= (ADDR_W+1)'(MEM_DEPTH));
    handle_ok = ({1'b0, req_handle} < count);
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && handle_ok) next_state = WRITE;
      end
      WRITE:   next_state = RD_A;
      RD_A:    next_state = RD_B;
      RD_B:    next_state = MIX;
      MIX:     next_state = GAIN;
      GAIN:    next_state = OUT;
      OUT:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)       state <= IDLE;
    else if (enable) state <= next_state;
  end

  // The read register only advances while enabled, so a stall holds the
  // word fetched before it and the pending read is re-issued on resume.
  always_ff @(posedge clk) begin
    if (enable) begin
      if (!reset && state == WRITE) mem[wr_addr] <= lat_sample;
      rd_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count        <= '0;
      next_base    <= '0;
      alloc_ack    <= 1'b0;
      alloc_err    <= 1'b0;
      alloc_handle <= '0;
      req_err      <= 1'b0;
      resp_valid   <= 1'b0;
      resp_handle  <= '0;
      resp_sample  <= '0;
      lat_handle   <= '0;
      lat_sample   <= '0;
      lat_inc      <= '0;
      a_q          <= '0;
      y_q          <= '0;
      out_q        <= '0;
    end else begin
      alloc_ack  <= 1'b0;
      alloc_err  <= 1'b0;
      req_err    <= 1'b0;
      resp_valid <= 1'b0;
      if (enable) begin
        if (alloc_req) begin
          if (alloc_ok) begin
            ch_base[count[CH_W-1:0]]  <= next_base[ADDR_W-1:0];
            ch_size[count[CH_W-1:0]]  <= alloc_size;
            ch_pos[count[CH_W-1:0]]   <= '0;
            ch_gain[count[CH_W-1:0]]  <= '0;
            ch_wrap[count[CH_W-1:0]]  <= 1'b0;
            ch_delay[count[CH_W-1:0]] <= alloc_dly;
            alloc_handle <= count[CH_W-1:0];
            alloc_ack    <= 1'b1;
            count        <= count + (CH_W+1)'(1);
            next_base    <= next_base + (ADDR_W+1)'(alloc_size);
          end else begin
            alloc_err <= 1'b1;
          end
        end
        case (state)
          IDLE: if (req_valid) begin
            if (handle_ok) begin
              lat_handle <= req_handle;
              lat_sample <= req_sample;
              lat_inc    <= req_delay_inc;
            end else begin
              req_err <= 1'b1;
            end
          end
          RD_B: a_q   <= rd_q;
          MIX:  y_q   <= y_next;
          GAIN: out_q <= sat_out;
          OUT: begin
            resp_valid           <= 1'b1;
            resp_handle          <= lat_handle;
            resp_sample          <= out_q;
            ch_pos[lat_handle]   <= pos_next;
            ch_gain[lat_handle]  <= gain_next;
            ch_delay[lat_handle] <= dly_next;
            if (pos_wrap) ch_wrap[lat_handle] <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
